// File: rtl/duck_pkg.sv
// Shared constants for the duck-hunt datapath.
// X_W/Y_W are the screen coordinate widths. SCREEN_W/SCREEN_H are the
// visible area. BIRD_BACK/BIRD_HALF_H describe the bird sprite box relative
// to the nose x / body-row y. Also holds the shot_checker state encoding.
package duck_pkg;

  localparam int X_W         = 8;
  localparam int Y_W         = 7;
  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int BIRD_BACK   = 5;
  localparam int BIRD_HALF_H = 3;

  typedef enum logic [1:0] {
    SC_IDLE   = 2'd0,
    SC_SCAN   = 2'd1,
    SC_REPORT = 2'd2
  } sc_state_t;

endpackage

// File: rtl/bird_hit_test.sv
// Combinational box test: is the crosshair inside one bird's sprite box?
// Box spans x in [bx-BIRD_BACK, bx] and y in [by-BIRD_HALF_H, by+BIRD_HALF_H].
// Ports:
//   i_cx, i_cy  crosshair position
//   i_bx, i_by  bird nose x / body-row y
//   i_alive     bird slot is shootable
//   o_hit       crosshair lies in the box of a live bird
module bird_hit_test
  import duck_pkg::*;
(
  input  logic [X_W-1:0] i_cx,
  input  logic [Y_W-1:0] i_cy,
  input  logic [X_W-1:0] i_bx,
  input  logic [Y_W-1:0] i_by,
  input  logic           i_alive,
  output logic           o_hit
);

  // Comparisons are done one bit wider and moved to the crosshair side where
  // possible, so a box near 0 clips instead of wrapping to the far edge.
  logic [X_W:0] w_cx;
  logic [X_W:0] w_bx;
  logic [Y_W:0] w_cy;
  logic [Y_W:0] w_by;
  logic         w_x_ok;
  logic         w_y_ok;

  assign w_cx = {1'b0, i_cx};
  assign w_bx = {1'b0, i_bx};
  assign w_cy = {1'b0, i_cy};
  assign w_by = {1'b0, i_by};

  assign w_x_ok = (w_cx <= w_bx) && ((w_cx + (X_W+1)'(BIRD_BACK)) >= w_bx);
  assign w_y_ok = (w_cy <= (w_by + (Y_W+1)'(BIRD_HALF_H))) &&
                  ((w_cy + (Y_W+1)'(BIRD_HALF_H)) >= w_by);

  assign o_hit = i_alive && w_x_ok && w_y_ok;

endmodule

// File: rtl/shot_checker.sv
// Resolves a hunter shot against all bird slots and keeps the score.
// A rising edge of fire snapshots the crosshair and all birds, then one slot
// is tested per clock; a one-cycle done/kill pulse reports the result.
// Ports:
//   clock, reset           clock, asynchronous active-high reset
//   fire                   trigger level (synchronous); shot = rising edge
//   cross_x, cross_y       crosshair position
//   bird_x, bird_y         packed bird positions, slot i at [8i+:8] / [7i+:7]
//   bird_alive             per-slot shootable flag
//   busy                   shot in progress (SCAN and REPORT)
//   done                   one-cycle pulse in REPORT
//   hit_mask               birds hit by the last shot, held until next capture
//   kill                   hit_mask during done, zero otherwise
//   score, shots           saturating totals of birds hit / shots resolved
module shot_checker
  import duck_pkg::*;
#(
  parameter int NUM_BIRDS = 6,
  parameter int SCORE_W   = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     fire,
  input  logic [X_W-1:0]           cross_x,
  input  logic [Y_W-1:0]           cross_y,
  input  logic [X_W*NUM_BIRDS-1:0] bird_x,
  input  logic [Y_W*NUM_BIRDS-1:0] bird_y,
  input  logic [NUM_BIRDS-1:0]     bird_alive,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_BIRDS-1:0]     hit_mask,
  output logic [NUM_BIRDS-1:0]     kill,
  output logic [SCORE_W-1:0]       score,
  output logic [SCORE_W-1:0]       shots
);

  localparam int IDX_W = (NUM_BIRDS > 1) ? $clog2(NUM_BIRDS) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  function automatic logic [3:0] f_popcount(input logic [NUM_BIRDS-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_BIRDS; i++) cnt = cnt + 4'(v[i]);
    return cnt;
  endfunction

  function automatic logic [SCORE_W-1:0] f_sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [3:0]         b);
    logic [SCORE_W+3:0] sum;
    sum = (SCORE_W+4)'(a) + (SCORE_W+4)'(b);
    if (sum > {4'b0, SCORE_MAX}) return SCORE_MAX;
    return sum[SCORE_W-1:0];
  endfunction

  sc_state_t             r_state;
  sc_state_t             w_state_next;
  logic                  r_fire_q;
  logic [IDX_W-1:0]      r_idx;
  logic [X_W-1:0]        r_cx_snap;
  logic [Y_W-1:0]        r_cy_snap;
  logic [X_W-1:0]        r_bx_snap [NUM_BIRDS];
  logic [Y_W-1:0]        r_by_snap [NUM_BIRDS];
  logic [NUM_BIRDS-1:0]  r_alive_snap;
  logic [NUM_BIRDS-1:0]  r_hit_mask;
  logic                  r_busy;
  logic                  r_done;
  logic [SCORE_W-1:0]    r_score;
  logic [SCORE_W-1:0]    r_shots;
  logic                  w_shot;
  logic                  w_last;
  logic                  w_hit;

  assign w_shot = fire & ~r_fire_q;
  assign w_last = (r_idx == IDX_W'(NUM_BIRDS - 1));

  // Single shared box tester, steered to the slot under scan.
  bird_hit_test u_hit (
    .i_cx    (r_cx_snap),
    .i_cy    (r_cy_snap),
    .i_bx    (r_bx_snap[r_idx]),
    .i_by    (r_by_snap[r_idx]),
    .i_alive (r_alive_snap[r_idx]),
    .o_hit   (w_hit)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= SC_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SC_IDLE:   if (w_shot) w_state_next = SC_SCAN;
      SC_SCAN:   if (w_last) w_state_next = SC_REPORT;
      SC_REPORT: w_state_next = SC_IDLE;
      default:   w_state_next = SC_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // fire_q starts high so a trigger held through reset is not a shot.
      r_fire_q     <= 1'b1;
      r_idx        <= '0;
      r_cx_snap    <= '0;
      r_cy_snap    <= '0;
      r_alive_snap <= '0;
      r_hit_mask   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_score      <= '0;
      r_shots      <= '0;
      for (int i = 0; i < NUM_BIRDS; i++) begin
        r_bx_snap[i] <= '0;
        r_by_snap[i] <= '0;
      end
    end else begin
      r_fire_q <= fire;
      r_busy   <= (w_state_next != SC_IDLE);
      r_done   <= (w_state_next == SC_REPORT);
      case (r_state)
        SC_IDLE: begin
          if (w_shot) begin
            r_cx_snap    <= cross_x;
            r_cy_snap    <= cross_y;
            r_alive_snap <= bird_alive;
            r_hit_mask   <= '0;
            r_idx        <= '0;
            for (int i = 0; i < NUM_BIRDS; i++) begin
              r_bx_snap[i] <= bird_x[X_W*i +: X_W];
              r_by_snap[i] <= bird_y[Y_W*i +: Y_W];
            end
          end
        end
        SC_SCAN: begin
          if (w_hit) r_hit_mask[r_idx] <= 1'b1;
          if (!w_last) r_idx <= r_idx + IDX_W'(1);
        end
        SC_REPORT: begin
          r_score <= f_sat_add(r_score, f_popcount(r_hit_mask));
          if (r_shots != SCORE_MAX) r_shots <= r_shots + SCORE_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hit_mask = r_hit_mask;
  assign kill     = r_done ? r_hit_mask : '0;
  assign score    = r_score;
  assign shots    = r_shots;

endmodule

// File: tb/tb_shot_checker.sv
module tb_shot_checker;

  localparam int NB = 6;
  localparam int SW = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic            fire;
  logic [7:0]      cross_x;
  logic [6:0]      cross_y;
  logic [8*NB-1:0] bird_x;
  logic [7*NB-1:0] bird_y;
  logic [NB-1:0]   bird_alive;
  logic            busy;
  logic            done;
  logic [NB-1:0]   hit_mask;
  logic [NB-1:0]   kill;
  logic [SW-1:0]   score;
  logic [SW-1:0]   shots;

  shot_checker #(.NUM_BIRDS(NB), .SCORE_W(SW)) dut (
    .clock      (clock),
    .reset      (reset),
    .fire       (fire),
    .cross_x    (cross_x),
    .cross_y    (cross_y),
    .bird_x     (bird_x),
    .bird_y     (bird_y),
    .bird_alive (bird_alive),
    .busy       (busy),
    .done       (done),
    .hit_mask   (hit_mask),
    .kill       (kill),
    .score      (score),
    .shots      (shots)
  );

  always #10 clock = ~clock;

  typedef struct {
    logic [7:0]           cx;
    logic [6:0]           cy;
    logic [NB-1:0][7:0]   bx;
    logic [NB-1:0][6:0]   by;
    logic [NB-1:0]        alive;
    logic [NB-1:0]        mask;
  } vec_t;

  typedef struct packed {
    logic [NB-1:0] mask;
    logic [SW-1:0] score;
    logic [SW-1:0] shots;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   errors = 0;
  int   checks = 0;
  int   exp_score = 0;
  int   exp_shots = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Birds parked far from every test crosshair and dead unless a vector sets them.
  function automatic vec_t mk(input logic [7:0] cx, input logic [6:0] cy);
    vec_t v;
    v.cx = cx;
    v.cy = cy;
    for (int i = 0; i < NB; i++) begin
      v.bx[i] = 8'(120 + 5 * i);
      v.by[i] = 7'd20;
    end
    v.alive = '0;
    v.mask  = '0;
    return v;
  endfunction

  task automatic do_shot(input vec_t v, input bit glitch);
    int   cnt;
    bit   seen;
    exp_t e;
    logic [7:0] ncx;
    logic [6:0] ncy;
    fire = 1'b0;
    @(negedge clock);
    cross_x    = v.cx;
    cross_y    = v.cy;
    bird_x     = v.bx;
    bird_y     = v.by;
    bird_alive = v.alive;
    fire       = 1'b1;
    exp_score  = exp_score + $countones(v.mask);
    if (exp_score > 255) exp_score = 255;
    if (exp_shots < 255) exp_shots = exp_shots + 1;
    sb.push_back({v.mask, 8'(exp_score), 8'(exp_shots)});
    @(posedge clock);
    #1;
    // After capture, move the crosshair and put every bird, alive, on it.
    ncx = v.cx ^ 8'h2A;
    ncy = v.cy ^ 7'h15;
    cross_x    = ncx;
    cross_y    = ncy;
    bird_x     = {NB{ncx}};
    bird_y     = {NB{ncy}};
    bird_alive = '1;
    cnt  = 0;
    seen = 0;
    while (!seen && cnt < 20) begin
      @(negedge clock);
      cnt++;
      if (cnt == 1) check("busy_scan", 32'(busy), 1);
      if (cnt == 3) check("kill_idle_scan", 32'(kill), 0);
      if (glitch && cnt == 2) fire = 1'b0;
      if (glitch && cnt == 3) fire = 1'b1;
      if (done) seen = 1;
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
      void'(sb.pop_front());
      fire = 1'b0;
      return;
    end
    check("done_latency", 32'(cnt), 7);
    e = sb.pop_front();
    check("hit_mask", 32'(hit_mask), 32'(e.mask));
    check("kill_in_done", 32'(kill), 32'(e.mask));
    check("busy_report", 32'(busy), 1);
    @(negedge clock);
    check("done_pulse", 32'(done), 0);
    check("kill_after", 32'(kill), 0);
    check("busy_after", 32'(busy), 0);
    check("score", 32'(score), 32'(e.score));
    check("shots", 32'(shots), 32'(e.shots));
    check("mask_held", 32'(hit_mask), 32'(e.mask));
    @(negedge clock);
    check("no_retrigger", 32'(busy), 0);
    fire = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset = 1'b1; fire = 1'b1;
    cross_x = '0; cross_y = '0; bird_x = '0; bird_y = '0; bird_alive = '0;

    // Basic hit on bird 2.
    tbl[0] = mk(8'd47, 7'd42); tbl[0].bx[2] = 8'd50; tbl[0].by[2] = 7'd40;
    tbl[0].alive = 6'b000100; tbl[0].mask = 6'b000100;
    // Box corners on bird 0 at (50,40).
    for (int i = 1; i <= 7; i++) begin
      tbl[i] = mk(8'd0, 7'd0); tbl[i].bx[0] = 8'd50; tbl[i].by[0] = 7'd40;
      tbl[i].alive = 6'b000001;
    end
    tbl[1].cx = 8'd45; tbl[1].cy = 7'd37; tbl[1].mask = 6'b000001;
    tbl[2].cx = 8'd50; tbl[2].cy = 7'd43; tbl[2].mask = 6'b000001;
    tbl[3].cx = 8'd44; tbl[3].cy = 7'd40; tbl[3].mask = 6'b000000;
    tbl[4].cx = 8'd51; tbl[4].cy = 7'd40; tbl[4].mask = 6'b000000;
    tbl[5].cx = 8'd50; tbl[5].cy = 7'd44; tbl[5].mask = 6'b000000;
    tbl[6].cx = 8'd50; tbl[6].cy = 7'd36; tbl[6].mask = 6'b000000;
    tbl[7].cx = 8'd46; tbl[7].cy = 7'd41; tbl[7].mask = 6'b000001;
    // Overlap with a dead slot at the same spot.
    tbl[8] = mk(8'd78, 7'd60);
    tbl[8].bx[0] = 8'd80; tbl[8].by[0] = 7'd60;
    tbl[8].bx[1] = 8'd80; tbl[8].by[1] = 7'd60;
    tbl[8].bx[3] = 8'd80; tbl[8].by[3] = 7'd60;
    tbl[8].alive = 6'b001001; tbl[8].mask = 6'b001001;
    // Low corner: clips at 0, never aliases to the far edge.
    tbl[9] = mk(8'd0, 7'd0); tbl[9].bx[0] = 8'd2; tbl[9].by[0] = 7'd1;
    tbl[9].alive = 6'b000001; tbl[9].mask = 6'b000001;
    tbl[10] = tbl[9]; tbl[10].cx = 8'd159; tbl[10].cy = 7'd119; tbl[10].mask = '0;
    // Far corner bird 5 at (159,119), crosshair on its back-top corner.
    tbl[11] = mk(8'd154, 7'd116); tbl[11].bx[5] = 8'd159; tbl[11].by[5] = 7'd119;
    tbl[11].alive = 6'b100000; tbl[11].mask = 6'b100000;

    // Reset state, then release with fire held high: no shot.
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mask", 32'(hit_mask), 0);
    check("rst_kill", 32'(kill), 0);
    check("rst_score", 32'(score), 0);
    check("rst_shots", 32'(shots), 0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("held_fire_busy", 32'(busy), 0);
    end
    check("held_fire_shots", 32'(shots), 0);

    for (int i = 0; i < 12; i++) do_shot(tbl[i], i == 8);

    // Reset asserted in the middle of a scan.
    fire = 1'b0;
    @(negedge clock);
    cross_x = tbl[0].cx; cross_y = tbl[0].cy;
    bird_x = tbl[0].bx; bird_y = tbl[0].by; bird_alive = tbl[0].alive;
    fire = 1'b1;
    @(posedge clock);
    repeat (3) @(negedge clock);
    check("pre_rst_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    exp_score = 0; exp_shots = 0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_score", 32'(score), 0);
    check("mid_rst_shots", 32'(shots), 0);
    check("mid_rst_mask", 32'(hit_mask), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check("mid_rst_no_done", 32'(done), 0);
      check("mid_rst_kill", 32'(kill), 0);
    end
    check("mid_rst_idle", 32'(busy), 0);

    // Saturation: six overlapping birds per shot, until both counters top out.
    v = mk(8'd100, 7'd103);
    for (int i = 0; i < NB; i++) begin
      v.bx[i] = 8'd100; v.by[i] = 7'd100;
    end
    v.alive = '1; v.mask = '1;
    for (int s = 0; s < 256; s++) do_shot(v, 1'b0);
    check("sat_score", 32'(score), 255);
    check("sat_shots", 32'(shots), 255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
